// File: rtl/gost89_pkg.sv
// Shared constants and types for the GOST 28147-89 gamma controller.
// Holds the counter step constants, bus widths and the controller states.
package gost89_pkg;

    localparam int BLK_W  = 64;
    localparam int KEY_W  = 256;
    localparam int SBOX_W = 512;

    localparam logic [31:0] GOST_C1 = 32'h01010104;
    localparam logic [31:0] GOST_C2 = 32'h01010101;

    // Guard values: ABORT leaves one cycle for the core reset pulse,
    // LOAD is the cycle on which load_data is driven.
    localparam logic [2:0] GUARD_ABORT = 3'd4;
    localparam logic [2:0] GUARD_LOAD  = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_READY = 3'd2,
        ST_GEN   = 3'd3,
        ST_OUT   = 3'd4
    } gamma_state_t;

    function automatic logic [31:0] rol11(input logic [31:0] x);
        return {x[20:0], x[31:21]};
    endfunction

endpackage

// File: rtl/gost89_ecb_encrypt.sv
// Iterative GOST 28147-89 ECB encryption core, one round per clock.
// Block layout: data[31:0] = N1, data[63:32] = N2; key word i = key[32i+:32].
module gost89_ecb_encrypt
    import gost89_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_data,
    input  logic [SBOX_W-1:0] sbox,
    input  logic [KEY_W-1:0]  key,
    input  logic [BLK_W-1:0]  data_in,
    output logic [BLK_W-1:0]  data_out,
    output logic              busy
);

    logic [31:0] n1_q, n1_d;
    logic [31:0] n2_q, n2_d;
    logic [4:0]  rnd_q, rnd_d;
    logic        busy_q, busy_d;

    logic [2:0]  kidx;
    logic [31:0] rkey;
    logic [31:0] sum;
    logic [31:0] sub;

    // Round function: key select, modular add, S-box substitution.
    always_comb begin
        kidx = (rnd_q[4:3] == 2'b11) ? ~rnd_q[2:0] : rnd_q[2:0];
        rkey = key[{kidx, 5'd0} +: 32];
        sum  = n1_q + rkey;
        sub  = '0;
        for (int i = 0; i < 8; i++) begin
            sub[i*4 +: 4] = sbox[{i[2:0], sum[i*4 +: 4], 2'b00} +: 4];
        end
    end

    // Round sequencing; every round swaps halves, so the output is read swapped.
    always_comb begin
        n1_d   = n1_q;
        n2_d   = n2_q;
        rnd_d  = rnd_q;
        busy_d = busy_q;
        if (load_data) begin
            n1_d   = data_in[31:0];
            n2_d   = data_in[63:32];
            rnd_d  = 5'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            n1_d  = n2_q ^ rol11(sub);
            n2_d  = n1_q;
            rnd_d = rnd_q + 5'd1;
            if (rnd_q == 5'd31) begin
                busy_d = 1'b0;
            end
        end
    end

    // Core state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n1_q   <= '0;
            n2_q   <= '0;
            rnd_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            n1_q   <= n1_d;
            n2_q   <= n2_d;
            rnd_q  <= rnd_d;
            busy_q <= busy_d;
        end
    end

    assign data_out = {n1_q, n2_q};
    assign busy     = busy_q;

endmodule

// File: rtl/gost89_gamma_step.sv
// Combinational gamma counter step.
// Low half advances mod 2^32, high half mod 2^32-1 (end-around carry).
module gost89_gamma_step
    import gost89_pkg::*;
(
    input  logic [BLK_W-1:0] ctr_i,
    output logic [BLK_W-1:0] ctr_o
);

    logic [32:0] hi_t;
    logic [31:0] hi_n;
    logic [31:0] lo_n;

    // Add the step constants; fold the high-half carry back in.
    always_comb begin
        hi_t  = {1'b0, ctr_i[63:32]} + {1'b0, GOST_C1};
        hi_n  = hi_t[31:0] + {31'd0, hi_t[32]};
        lo_n  = ctr_i[31:0] + GOST_C2;
        ctr_o = {hi_n, lo_n};
    end

endmodule

// File: rtl/gost89_gamma_ctrl.sv
// GOST 28147-89 counter-mode stream controller around one ECB core.
// One block in flight; iv_load restarts the stream from any state.
module gost89_gamma_ctrl
    import gost89_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [SBOX_W-1:0] sbox,
    input  logic [KEY_W-1:0]  key,
    input  logic              iv_load,
    input  logic [BLK_W-1:0]  iv,
    input  logic              in_valid,
    input  logic [BLK_W-1:0]  in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [BLK_W-1:0]  out_data,
    input  logic              out_ready,
    output logic              busy
);

    gamma_state_t     state_q, state_d;
    logic [BLK_W-1:0] ctr_q, ctr_d;
    logic [BLK_W-1:0] din_q, din_d;
    logic [BLK_W-1:0] out_q, out_d;
    logic [2:0]       guard_q, guard_d;
    logic             seen_q, seen_d;
    logic             abort_q, abort_d;

    logic             core_load;
    logic             core_busy;
    logic             core_rst;
    logic [BLK_W-1:0] core_out;
    logic [BLK_W-1:0] ctr_step;

    gost89_gamma_step u_step (
        .ctr_i (ctr_q),
        .ctr_o (ctr_step)
    );

    // The core input is always the counter: it holds the iv during INIT.
    gost89_ecb_encrypt u_core (
        .clk       (clk),
        .reset     (core_rst),
        .load_data (core_load),
        .sbox      (sbox),
        .key       (key),
        .data_in   (ctr_q),
        .data_out  (core_out),
        .busy      (core_busy)
    );

    assign core_rst = reset | abort_q;

    // Next-state logic; iv_load overrides everything else.
    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        din_d     = din_q;
        out_d     = out_q;
        guard_d   = guard_q;
        seen_d    = seen_q;
        abort_d   = 1'b0;
        core_load = 1'b0;
        if (iv_load) begin
            state_d = ST_INIT;
            ctr_d   = iv;
            guard_d = GUARD_ABORT;
            seen_d  = 1'b0;
            abort_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_INIT, ST_GEN: begin
                    core_load = (guard_q == GUARD_LOAD);
                    if (guard_q != 3'd0) begin
                        guard_d = guard_q - 3'd1;
                    end else if (core_busy) begin
                        seen_d = 1'b1;
                    end else if (seen_q) begin
                        seen_d = 1'b0;
                        if (state_q == ST_INIT) begin
                            ctr_d   = core_out;
                            state_d = ST_READY;
                        end else begin
                            out_d   = din_q ^ core_out;
                            state_d = ST_OUT;
                        end
                    end
                end
                ST_READY: begin
                    if (in_valid) begin
                        din_d   = in_data;
                        ctr_d   = ctr_step;
                        guard_d = GUARD_LOAD;
                        seen_d  = 1'b0;
                        state_d = ST_GEN;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_d = ST_READY;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ctr_q   <= '0;
            din_q   <= '0;
            out_q   <= '0;
            guard_q <= '0;
            seen_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            din_q   <= din_d;
            out_q   <= out_d;
            guard_q <= guard_d;
            seen_q  <= seen_d;
            abort_q <= abort_d;
        end
    end

    assign in_ready  = (state_q == ST_READY) & ~iv_load;
    assign out_valid = (state_q == ST_OUT) & ~iv_load;
    assign out_data  = out_q;
    assign busy      = (state_q == ST_INIT) | (state_q == ST_GEN);

endmodule

// File: tb/tb_gost89_gamma_ctrl.sv
// Scoreboard bench for gost89_gamma_ctrl with a software gamma model.
// Stimulus pushes expected blocks; an independent monitor pops and compares.
module tb_gost89_gamma_ctrl;

    localparam logic [63:0] IV0 = 64'h0123456789abcdef;
    localparam logic [63:0] B0  = 64'hd5a8a608f4f115b4;
    localparam logic [63:0] B1  = 64'h389eb44a391474c4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [511:0] sbox;
    logic [255:0] key;
    logic         iv_load = 1'b0;
    logic [63:0]  iv = '0;
    logic         in_valid = 1'b0;
    logic [63:0]  in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [63:0]  out_data;
    logic         out_ready = 1'b0;
    logic         busy;

    logic [63:0]  st_i = '0;
    logic [63:0]  st_o;

    int           checks = 0;
    int           errors = 0;
    logic [63:0]  exp_q[$];
    logic [63:0]  cap_q[$];
    logic [63:0]  m_ctr = '0;
    bit           rnd_mode = 1'b0;

    int unsigned tbl[8][16] = '{
        '{4, 10, 9, 2, 13, 8, 0, 14, 6, 11, 1, 12, 7, 15, 5, 3},
        '{14, 11, 4, 12, 6, 13, 15, 10, 2, 3, 8, 1, 0, 7, 5, 9},
        '{5, 8, 1, 13, 10, 3, 4, 2, 14, 15, 12, 7, 6, 0, 9, 11},
        '{7, 13, 10, 1, 0, 8, 9, 15, 14, 4, 6, 12, 11, 2, 5, 3},
        '{6, 12, 7, 1, 5, 15, 13, 8, 4, 10, 9, 14, 0, 3, 11, 2},
        '{4, 11, 10, 0, 7, 2, 1, 13, 3, 6, 8, 5, 9, 12, 15, 14},
        '{13, 11, 4, 1, 3, 15, 5, 9, 0, 10, 14, 7, 6, 8, 2, 12},
        '{1, 15, 13, 0, 5, 7, 10, 4, 9, 2, 3, 14, 6, 11, 8, 12}
    };

    logic [31:0] kw[8] = '{
        32'h733d2c20, 32'h65686573, 32'h74746769, 32'h79676120,
        32'h626e7373, 32'h20657369, 32'h326c6568, 32'h33206d54
    };

    gost89_gamma_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .sbox      (sbox),
        .key       (key),
        .iv_load   (iv_load),
        .iv        (iv),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    gost89_gamma_step u_step_ut (
        .ctr_i (st_i),
        .ctr_o (st_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] f_gost(input logic [31:0] x);
        logic [31:0] s;
        s = 0;
        for (int i = 0; i < 8; i++)
            s = s | (32'(tbl[i][(x >> (4 * i)) & 32'hf]) << (4 * i));
        return (s << 11) | (s >> 21);
    endfunction

    // Textbook GOST encryption: 31 swapping rounds, last round unswapped.
    function automatic logic [63:0] enc(input logic [63:0] b);
        logic [31:0] n1, n2, t, k;
        n1 = b[31:0];
        n2 = b[63:32];
        for (int r = 0; r < 32; r++) begin
            k = (r < 24) ? kw[r % 8] : kw[7 - (r % 8)];
            if (r < 31) begin
                t  = n1;
                n1 = n2 ^ f_gost(n1 + k);
                n2 = t;
            end else begin
                n2 = n2 ^ f_gost(n1 + k);
            end
        end
        return {n2, n1};
    endfunction

    function automatic logic [63:0] m_step(input logic [63:0] c);
        longint unsigned hi, lo;
        hi = 64'(c[63:32]);
        lo = 64'(c[31:0]);
        lo = (lo + 64'h01010101) % 64'h100000000;
        hi = hi + 64'h01010104;
        if (hi > 64'hffffffff) hi = hi - 64'hffffffff;
        return {hi[31:0], lo[31:0]};
    endfunction

    task automatic do_iv(input logic [63:0] v);
        iv_load = 1'b1;
        iv = v;
        m_ctr = enc(v);
        exp_q.delete();
        @(negedge clk);
        chk("ivload_in_ready", 64'(in_ready), 64'd0);
        chk("ivload_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        iv_load = 1'b0;
    endtask

    task automatic xfer(input logic [63:0] d, input bit raw,
                        input logic [63:0] e, output int cyc);
        bit take;
        take = 1'b0;
        cyc = 0;
        in_valid = 1'b1;
        in_data = d;
        for (int n = 0; n < 400 && !take; n++) begin
            @(negedge clk);
            take = in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        if (!take) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got 0 exp 1");
        end else begin
            m_ctr = m_step(m_ctr);
            exp_q.push_back(raw ? e : (d ^ enc(m_ctr)));
        end
    endtask

    task automatic send(input logic [63:0] d);
        int c;
        xfer(d, 1'b0, '0, c);
    endtask

    task automatic drain();
        for (int n = 0; n < 400 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
            if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d exp 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_ov(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 200);
    endtask

    // Monitor: every out handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready && !iv_load) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", out_data, 64'hx);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
                cap_q.push_back(out_data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c;
        bit bad;
        logic [63:0] c0, c1, snap, x, y;

        for (int i = 0; i < 8; i++) begin
            key[i*32 +: 32] = kw[i];
            for (int v = 0; v < 16; v++)
                sbox[(i*16 + v)*4 +: 4] = 4'(tbl[i][v]);
        end

        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        st_i = 64'hfefefefb_ffffffff;
        #1;
        chk("step_wrap", st_o, 64'hffffffff_01010100);
        st_i = 64'hffffffff_00000000;
        #1;
        chk("step_carry", st_o, 64'h01010104_01010101);
        for (int i = 0; i < 4; i++) begin
            st_i = {$urandom, $urandom};
            #1;
            chk("step_rand", st_o, m_step(st_i));
        end

        out_ready = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;

        do_iv(IV0);
        chk("init_busy", 64'(busy), 64'd1);
        cap_q.delete();
        send(B0);
        wait_ov(n);
        chk("latency", 64'(n), 64'd35);
        drain();
        send(B1);
        drain();
        c0 = cap_q.size() > 0 ? cap_q[0] : '0;
        c1 = cap_q.size() > 1 ? cap_q[1] : '0;
        do_iv(IV0);
        xfer(c0, 1'b1, B0, c);
        drain();
        xfer(c1, 1'b1, B1, c);
        drain();

        out_ready = 1'b0;
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        send(x);
        wait_ov(n);
        snap = out_data;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!out_valid || out_data !== snap || in_ready) bad = 1'b1;
        end
        chk("bp_hold", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        xfer(y, 1'b0, '0, c);
        chk("bp_accept_cycles", 64'(c), 64'd2);
        drain();

        do_iv(64'h1122334455667788);
        send({$urandom, $urandom});
        repeat (12) @(posedge clk);
        #1;
        do_iv(64'hcafef00d12345678);
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) bad = 1'b1;
        end
        chk("abort_no_out", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        send(B0);
        drain();

        send({$urandom, $urandom});
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_data", out_data, 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("arst_idle_busy", 64'(busy), 64'd0);
        do_iv(IV0);
        send(B0);
        drain();
        send(B1);
        drain();

        do_iv(64'h0f1e2d3c4b5a6978);
        out_ready = 1'b0;
        send(64'd0);
        wait_ov(n);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        do_iv(64'h8796a5b4c3d2e1f0);
        send(64'd0);
        drain();
        send(64'd0);
        drain();

        rnd_mode = 1'b1;
        do_iv({$urandom, $urandom});
        for (int i = 0; i < 10; i++) send({$urandom, $urandom});
        drain();
        rnd_mode = 1'b0;
        out_ready = 1'b1;

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
